// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: opcodes, status-register bit indices and responder FSM encoding shared with the flash-lock initiator
package spi_flash_pkg;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_WRDI  = 8'h04;
  localparam logic [7:0] CMD_RDSR1 = 8'h05;
  localparam logic [7:0] CMD_RDSR2 = 8'h35;
  localparam logic [7:0] CMD_WRSR1 = 8'h01;
  localparam logic [7:0] CMD_WRSR2 = 8'h31;
  localparam int SR1_WIP = 0;
  localparam int SR1_WEL = 1;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR1  = 3'd3;
  localparam logic [2:0] ST_WR2  = 3'd4;
  localparam logic [2:0] ST_WR1B = 3'd5;
  localparam logic [2:0] ST_SINK = 3'd6;
endpackage

// File: rtl/spi_slave_phy.sv
// spi_slave_phy: oversampling SPI mode-0 front end (synchronizers, edge detect, byte deframing, MISO shifter)
module spi_slave_phy (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       spi_miso,
  output logic       cs_n,
  output logic       cs_rise,
  output logic       byte_stb,
  output logic       cnt_zero,
  output logic [7:0] rx_byte
);
  logic [1:0] sck_s, cs_s, mosi_s;
  logic       sck_d, cs_d, rise, fall;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic [7:0] tx_sh;
  assign cs_n     = cs_s[1];
  assign rise     = sck_s[1] & ~sck_d & ~cs_n;
  assign fall     = ~sck_s[1] & sck_d & ~cs_n;
  assign cs_rise  = cs_n & ~cs_d;
  assign cnt_zero = cnt == 3'd0;
  assign byte_stb = rise & (cnt == 3'd7);
  assign rx_byte  = {sh, mosi_s[1]};
  // two-flop synchronizers plus the delay flops used for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sck_s  <= 2'b00;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sck_d  <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sck_s  <= {sck_s[0], spi_clk};
      cs_s   <= {cs_s[0], spi_cs_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sck_d  <= sck_s[1];
      cs_d   <= cs_n;
    end
  // MSB-first receive shift and bit count; deselect discards any partial byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 3'd0;
      sh  <= 7'd0;
    end else if (cs_n) cnt <= 3'd0;
    else if (rise) begin
      cnt <= cnt + 3'd1;
      sh  <= rx_byte[6:0];
    end
  // transmit: a fresh register copy is latched at each byte boundary, one bit per falling edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      spi_miso <= 1'b0;
      tx_sh    <= 8'd0;
    end else if (!tx_en || cs_n) spi_miso <= 1'b0;
    else if (fall) begin
      if (cnt_zero) begin
        tx_sh    <= tx_data;
        spi_miso <= tx_data[7];
      end else spi_miso <= tx_sh[3'd7 - cnt];
    end
endmodule

// File: rtl/spi_flash_sr_resp.sv
// spi_flash_sr_resp: QSPI NOR status-register responder (WREN/WRDI/RDSR1/RDSR2/WRSR/WRSR2); busy emulation under SPI_FLASH_SR_RESP_BUSY_EN
module spi_flash_sr_resp
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] SR1_INIT    = 8'h00,
  parameter logic [7:0] SR2_INIT    = 8'h00,
  parameter int         BUSY_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] sr1,
  output logic [7:0] sr2,
  output logic       cmd_stb,
  output logic [7:0] cmd,
  output logic       wr_commit
);
  logic       cs_n, cs_rise, byte_stb, cnt_zero, commit, wel, wip, rd_sel, have1, have2;
  logic [7:0] rx_byte, tx_data;
  logic [5:0] sr1_hi, st1;
  logic [7:0] st2;
  logic [2:0] state, nxt_cmd;
  spi_slave_phy u_phy (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .tx_en    (state == ST_RD),
    .tx_data  (tx_data),
    .spi_miso (spi_miso),
    .cs_n     (cs_n),
    .cs_rise  (cs_rise),
    .byte_stb (byte_stb),
    .cnt_zero (cnt_zero),
    .rx_byte  (rx_byte)
  );
  assign spi_miso_oe = ~cs_n;
  assign commit      = cs_rise & (have1 | have2) & cnt_zero;
  assign tx_data     = rd_sel ? sr2 : sr1;
  // status register 1 view: writable bits, WEL and WIP
  always_comb begin
    sr1          = {sr1_hi, 2'b00};
    sr1[SR1_WEL] = wel;
    sr1[SR1_WIP] = wip;
  end
  // command decode; writes are refused without WEL or while busy
  always_comb
    nxt_cmd = (rx_byte == CMD_RDSR1 || rx_byte == CMD_RDSR2) ? ST_RD :
              (rx_byte == CMD_WRSR1 && wel && !wip) ? ST_WR1 :
              (rx_byte == CMD_WRSR2 && wel && !wip) ? ST_WR2 : ST_SINK;
  // command FSM, data staging and commit on deselect
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_IDLE;
      sr1_hi    <= SR1_INIT[7:2];
      sr2       <= SR2_INIT;
      wel       <= 1'b0;
      cmd       <= 8'h00;
      cmd_stb   <= 1'b0;
      wr_commit <= 1'b0;
      rd_sel    <= 1'b0;
      have1     <= 1'b0;
      have2     <= 1'b0;
      st1       <= 6'd0;
      st2       <= 8'd0;
    end else begin
      cmd_stb   <= 1'b0;
      wr_commit <= commit;
      if (cs_n) begin
        state <= ST_IDLE;
        have1 <= 1'b0;
        have2 <= 1'b0;
        if (commit) begin
          if (have1) sr1_hi <= st1;
          if (have2) sr2 <= st2;
          wel <= 1'b0;
        end
      end else if (state == ST_IDLE) state <= ST_CMD;
      else if (byte_stb)
        case (state)
          ST_CMD: begin
            cmd     <= rx_byte;
            cmd_stb <= 1'b1;
            state   <= nxt_cmd;
            rd_sel  <= rx_byte == CMD_RDSR2;
            if (rx_byte == CMD_WREN && !wip) wel <= 1'b1;
            if (rx_byte == CMD_WRDI) wel <= 1'b0;
          end
          ST_WR1: begin
            st1   <= rx_byte[7:2];
            have1 <= 1'b1;
            state <= ST_WR1B;
          end
          ST_WR1B, ST_WR2: begin
            st2   <= rx_byte;
            have2 <= 1'b1;
            state <= ST_SINK;
          end
          default: ;
        endcase
    end
`ifdef SPI_FLASH_SR_RESP_BUSY_EN
  localparam int BW = $clog2(BUSY_CYCLES + 2);
  logic [BW-1:0] busy_cnt;
  // WIP stays set for BUSY_CYCLES clocks after each commit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wip      <= 1'b0;
      busy_cnt <= '0;
    end else if (commit) begin
      wip      <= 1'b1;
      busy_cnt <= BW'(BUSY_CYCLES);
    end else if (wip) begin
      busy_cnt <= busy_cnt - 1'b1;
      wip      <= busy_cnt > BW'(1);
    end
`else
  assign wip = 1'b0;
`endif
endmodule

// File: doc/spi_flash_sr_resp.md
Name: spi_flash_sr_resp

Overview:
- SPI mode-0 responder that emulates the status-register subset of a QSPI NOR flash: WREN, WRDI, RDSR1, RDSR2, WRSR, WRSR2.
- Gives the flash-lock initiator a synthesizable target for on-board loopback and simulation, with no real flash needed.
- Runs entirely in the clk domain and oversamples the SPI pins.
- Exposes its register state so test logic can check what the initiator wrote.

Parameters:
- SR1_INIT, 8'h00, reset value of status register 1; bits [1:0] are forced to 0.
- SR2_INIT, 8'h00, reset value of status register 2.
- BUSY_CYCLES, 1024, clk cycles WIP stays set after a write commit (used only with the optional feature).

Ports:
- clk  in  1  system clock; must be at least 8x the spi_clk frequency.
- rst  in  1  reset, asynchronous, active-high.
- spi_clk  in  1  SPI clock from initiator, idle low.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  initiator data, MSB first.
- spi_miso  out  1  responder data, registered.
- spi_miso_oe  out  1  high while a transaction is active (synchronized CS low).
- sr1  out  8  current status register 1.
- sr2  out  8  current status register 2.
- cmd_stb  out  1  one-cycle pulse when a command byte completes.
- cmd  out  8  last command byte; held until the next cmd_stb.
- wr_commit  out  1  one-cycle pulse when a status-register write is applied.

Behaviour:
- Reset values: sr1 = SR1_INIT & 8'hFC, sr2 = SR2_INIT, cmd = 0, spi_miso = 0, spi_miso_oe = 0, cmd_stb = 0, wr_commit = 0. FSM state = IDLE.
- Synchronizers: spi_clk, spi_cs_n and spi_mosi each pass through a 2-FF synchronizer. spi_cs_n synchronizer flops reset to 1.
- Edge detect: a third flop on the synchronized SCK produces rise and fall strobes. Rise samples synchronized MOSI.
- SCK edges are ignored while synchronized CS is high.
- Deframing: an 8-bit shift register and a 3-bit bit counter, MSB first. A byte completes on the rise that brings the count to 8; the counter then wraps to 0.
- FSM states:
  - IDLE: entered whenever synchronized CS is high.
  - CMD: entered on CS fall; collects the first byte.
  - RD: command 0x05 or 0x35.
  - WR1: command 0x01 and WEL = 1.
  - WR2: command 0x31 and WEL = 1.
  - WR1B: second data byte for 0x01.
  - SINK: everything else, including a write command when WEL = 0.
- Command byte completion: pulse cmd_stb and load cmd. Then:
  - 0x06: set WEL (sr1[1]) at completion.
  - 0x04: clear WEL at completion.
  - Both then go to SINK.
- RD: spi_miso presents the selected register MSB first.
  - The first bit drives on the fall after the 8th command rise.
  - Later bits drive on each following fall.
  - The register is re-read continuously, so every byte is a fresh copy (a live WIP change is visible).
  - Worst case sck-fall to miso latency is 4 clk.
- WR1: the first data byte is staged as sr1 data, then the FSM moves to WR1B. In WR1B, a second byte is staged as sr2 data; any further bytes are ignored.
- WR2: one byte is staged as sr2 data; further bytes are ignored.
- Commit happens on CS rise, and only if at least one full data byte was staged and the bit counter is 0. A partial byte aborts the write with no change.
  - Bits sr1[7:2] take the staged sr1 byte when one was received. sr2 takes its staged byte when one was received.
  - WEL is cleared and wr_commit pulses for 1 cycle.
- SINK: spi_miso = 0 and no register effects.
- spi_miso is 0 whenever the FSM is not in RD.
- CS rise mid-byte: discard the partial byte, return to IDLE, and take no action except a pending valid commit.
- Simultaneous CS rise and SCK rise: CS wins and the edge is dropped.
- Async rst mid-transaction: everything returns to reset values immediately.

Optional Feature:
- Macro: SPI_FLASH_SR_RESP_BUSY_EN.
- When defined:
  - A commit sets WIP (sr1[0]) and loads a down-counter with BUSY_CYCLES.
  - WIP clears when the counter reaches 0.
  - While WIP = 1, WREN, WRSR and WRSR2 are decoded but have no effect (go to SINK).
  - RDSR still works and reports WIP.
- When undefined: sr1[0] is constant 0, no counter is synthesized, and BUSY_CYCLES is unused.

Decomposition:
- Shared package spi_flash_pkg holds:
  - command opcodes (CMD_WREN = 8'h06, CMD_WRDI = 8'h04, CMD_RDSR1 = 8'h05, CMD_RDSR2 = 8'h35, CMD_WRSR1 = 8'h01, CMD_WRSR2 = 8'h31);
  - SR bit indices (SR1_WIP = 0, SR1_WEL = 1);
  - the FSM state encoding.
- The flash-lock initiator reuses the same opcodes.
- One sub-module, spi_slave_phy: synchronizers, edge detect, bit counter, RX shift, TX shift, byte strobe. The top level keeps the command FSM and registers.

Test Plan:
1. After reset with SR1_INIT = 8'h5F: sr1 reads 8'h5C. RDSR1 (0x05) + 8 clocks returns 8'h5C on MISO.
2. WRSR1 0x01 + 8'h3C without a prior WREN: sr1 unchanged and no wr_commit. Then WREN; WRSR1 0x01 + 8'h3C: on CS rise sr1 = 8'h3C, wr_commit pulses once, WEL = 0.
3. WREN; 0x01 + 8'h00 + 8'h42: sr2 = 8'h42. WREN; 0x31 + 8'h02 + 8'hFF: sr2 = 8'h02 (extra byte ignored).
4. WREN; 0x01 then 5 bits then CS rise: no commit, sr1 keeps WEL = 1. Command 0xAB + 3 bytes: MISO stays 0 and cmd = 8'hAB.
5. RDSR1 held for 24 clocks right after a WREN: three identical bytes 8'h02. With SCK at clk/8, every MISO bit is stable before the next rise.
6. BUSY_EN, BUSY_CYCLES = 16: after a commit, polling 0x05 shows bit0 = 1. A WREN during busy leaves WEL = 0. WIP reads 0 once 16 clk have elapsed.
